// File: rtl/rgmii_link_speed_ctrl.sv
// rgmii_link_speed_ctrl
// Derives link, duplex and speed from the PHY's RGMII in-band status and
// sequences speed changes: hold off MAC TX at a frame boundary, reset the
// PHY interface, switch speed, then release. Lives in the gmii_gtx_clk domain.
module rgmii_link_speed_ctrl #(
  parameter int         STABLE_COUNT  = 16,
  parameter int         HOLD_CYCLES   = 64,
  parameter logic [1:0] DEFAULT_SPEED = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  input  logic [3:0] gmii_rxd,
  input  logic       mac_tx_busy,
  output logic [1:0] speed,
  output logic       link_up,
  output logic       full_duplex,
  output logic       mac_tx_hold,
  output logic       phy_if_rst,
  output logic       speed_change
);

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_COUNT);
  localparam logic [9:0] HOLD_INIT  = 10'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_RUN       = 2'd1,
    ST_WAIT_IDLE = 2'd2
  } state_t;

  // Filter counter increment that sticks at the acceptance threshold.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= STABLE_LIM) ? STABLE_LIM : v + 8'd1;
  endfunction

  // ---- stage p0/p1: two-flop synchronizer, {dv, er, rxd[3:0]} ----
  logic [5:0] rx_p0;
  logic [5:0] rx_p1;

  // Bring the RX-clock-domain status into clk; multi-bit skew is tolerated
  // because the stability filter below needs many identical samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0 <= '0;
      rx_p1 <= '0;
    end else begin
      rx_p0 <= {gmii_rx_dv, gmii_rx_er, gmii_rxd};
      rx_p1 <= rx_p0;
    end
  end

  // ---- stage p2: in-band status stability filter ----
  logic       smp_vld;
  logic [3:0] smp;
  logic [3:0] cand;
  logic [7:0] filt_cnt;
  logic [7:0] filt_cnt_nxt;
  logic       accept;
  logic [1:0] acc_speed;

  // In-band status is only carried between frames (dv=0, er=0).
  assign smp_vld = ~rx_p1[5] & ~rx_p1[4];
  assign smp     = rx_p1[3:0];

  // Work out the next filter count and whether this edge completes a run.
  always_comb begin
    filt_cnt_nxt = filt_cnt;
    accept       = 1'b0;
    if (smp_vld) begin
      if (smp == cand) begin
        filt_cnt_nxt = sat_inc(filt_cnt);
      end else begin
        filt_cnt_nxt = 8'd1;
      end
      accept = (filt_cnt_nxt == STABLE_LIM) && (filt_cnt != STABLE_LIM);
    end
  end

  // Track the candidate and load the accepted status once it has been stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand        <= '0;
      filt_cnt    <= '0;
      link_up     <= 1'b0;
      full_duplex <= 1'b0;
      acc_speed   <= DEFAULT_SPEED;
    end else begin
      if (smp_vld) begin
        cand <= smp;
      end
      filt_cnt <= filt_cnt_nxt;
      if (accept) begin
        link_up     <= smp[0];
        full_duplex <= smp[3];
        // Speed code 2'b11 is reserved; keep the previous accepted speed.
        if (smp[2:1] != 2'b11) begin
          acc_speed <= smp[2:1];
        end
      end
    end
  end

  // ---- speed switch sequencer ----
  state_t     state;
  state_t     state_nxt;
  logic [9:0] hold_cnt;
  logic [9:0] hold_cnt_nxt;
  logic [1:0] target;
  logic [1:0] target_nxt;
  logic [1:0] speed_nxt;
  logic       speed_change_nxt;

  // Next-state and output decode for the quiesce / reset / switch sequence.
  always_comb begin
    state_nxt        = state;
    hold_cnt_nxt     = hold_cnt;
    target_nxt       = target;
    speed_nxt        = speed;
    speed_change_nxt = 1'b0;
    phy_if_rst       = 1'b0;
    mac_tx_hold      = 1'b1;
    case (state)
      ST_HOLD: begin
        phy_if_rst = 1'b1;
        if (hold_cnt == '0) begin
          state_nxt = ST_RUN;
        end else begin
          hold_cnt_nxt = hold_cnt - 10'd1;
        end
      end
      ST_RUN: begin
        mac_tx_hold = ~link_up;
        if (link_up && (acc_speed != speed)) begin
          target_nxt = acc_speed;
          state_nxt  = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        // A link drop abandons the switch; otherwise wait for a frame gap.
        if (!link_up) begin
          state_nxt = ST_RUN;
        end else if (!mac_tx_busy) begin
          speed_nxt        = target;
          speed_change_nxt = 1'b1;
          hold_cnt_nxt     = HOLD_INIT;
          state_nxt        = ST_HOLD;
        end
      end
      default: begin
        state_nxt = ST_HOLD;
      end
    endcase
  end

  // Sequencer registers; reset re-runs the initial PHY interface hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_HOLD;
      hold_cnt     <= HOLD_INIT;
      target       <= DEFAULT_SPEED;
      speed        <= DEFAULT_SPEED;
      speed_change <= 1'b0;
    end else begin
      state        <= state_nxt;
      hold_cnt     <= hold_cnt_nxt;
      target       <= target_nxt;
      speed        <= speed_nxt;
      speed_change <= speed_change_nxt;
    end
  end

endmodule

// File: tb/tb_rgmii_link_speed_ctrl.sv
// Bench for rgmii_link_speed_ctrl: directed in-band status sequences, a
// behavioural model compared every cycle, plus hand-computed literal checks.
module tb_rgmii_link_speed_ctrl;

  localparam int STABLE = 16;
  localparam int HOLD   = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv;
  logic       er;
  logic [3:0] rxd;
  logic       busy;
  logic [1:0] speed;
  logic       link_up;
  logic       full_duplex;
  logic       mac_tx_hold;
  logic       phy_if_rst;
  logic       speed_change;

  int checks   = 0;
  int failures = 0;
  int sc_count = 0;
  int s0;

  rgmii_link_speed_ctrl #(
    .STABLE_COUNT (STABLE),
    .HOLD_CYCLES  (HOLD),
    .DEFAULT_SPEED(2'b10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .gmii_rx_dv  (dv),
    .gmii_rx_er  (er),
    .gmii_rxd    (rxd),
    .mac_tx_busy (busy),
    .speed       (speed),
    .link_up     (link_up),
    .full_duplex (full_duplex),
    .mac_tx_hold (mac_tx_hold),
    .phy_if_rst  (phy_if_rst),
    .speed_change(speed_change)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [5:0] m_dl [2];     // sync delay line: [0]=one edge old, [1]=two
  logic [3:0] m_q [$];      // most recent valid in-band samples
  logic       m_link;
  logic       m_dup;
  logic [1:0] m_acc;
  logic [1:0] m_speed;
  logic [1:0] m_target;
  logic       m_sc;
  logic       m_wait;
  int         m_hold_left;  // remaining cycles with PHY interface held

  task automatic model_reset();
    m_dl[0]     = '0;
    m_dl[1]     = '0;
    m_q.delete();
    m_link      = 1'b0;
    m_dup       = 1'b0;
    m_acc       = 2'b10;
    m_speed     = 2'b10;
    m_target    = 2'b10;
    m_sc        = 1'b0;
    m_wait      = 1'b0;
    m_hold_left = HOLD;
  endtask

  task automatic model_step();
    logic [5:0] smp;
    logic [3:0] v;
    bit         same;
    m_sc = 1'b0;
    if (m_hold_left > 0) begin
      m_hold_left--;
    end else if (m_wait) begin
      if (!m_link) begin
        m_wait = 1'b0;
      end else if (!busy) begin
        m_speed     = m_target;
        m_sc        = 1'b1;
        m_wait      = 1'b0;
        m_hold_left = HOLD;
      end
    end else if (m_link && (m_acc != m_speed)) begin
      m_target = m_acc;
      m_wait   = 1'b1;
    end
    smp     = m_dl[1];
    m_dl[1] = m_dl[0];
    m_dl[0] = {dv, er, rxd};
    if (!smp[5] && !smp[4]) begin
      m_q.push_back(smp[3:0]);
      if (m_q.size() > STABLE) void'(m_q.pop_front());
      if (m_q.size() == STABLE) begin
        same = 1'b1;
        v    = m_q[0];
        foreach (m_q[i]) if (m_q[i] != v) same = 1'b0;
        if (same) begin
          m_link = v[0];
          m_dup  = v[3];
          if (v[2:1] != 2'b11) m_acc = v[2:1];
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("speed",        int'(speed),        int'(m_speed));
      chk("link_up",      int'(link_up),      int'(m_link));
      chk("full_duplex",  int'(full_duplex),  int'(m_dup));
      chk("mac_tx_hold",  int'(mac_tx_hold),  int'(m_hold_left > 0 || m_wait || !m_link));
      chk("phy_if_rst",   int'(phy_if_rst),   int'(m_hold_left > 0));
      chk("speed_change", int'(speed_change), int'(m_sc));
      if (speed_change) sc_count++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic go(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst  = 1'b1;
    dv   = 1'b0;
    er   = 1'b0;
    rxd  = 4'b0000;
    busy = 1'b0;
    go(3);
    chk("rst_phy",   int'(phy_if_rst),   1);
    chk("rst_hold",  int'(mac_tx_hold),  1);
    chk("rst_speed", int'(speed),        2);
    chk("rst_link",  int'(link_up),      0);
    chk("rst_sc",    int'(speed_change), 0);
    rst = 1'b0;

    // Reset release, idle PHY
    go(63);
    chk("init_phy_63", int'(phy_if_rst), 1);
    go(1);
    chk("init_phy_64",  int'(phy_if_rst),  0);
    chk("init_speed",   int'(speed),       2);
    chk("init_link",    int'(link_up),     0);
    chk("init_hold",    int'(mac_tx_hold), 1);

    // Link up at 1G full duplex: 18-cycle latency
    rxd = 4'b1101;
    s0  = sc_count;
    go(17);
    chk("up_link_17", int'(link_up), 0);
    go(1);
    chk("up_link_18", int'(link_up),     1);
    chk("up_fd_18",   int'(full_duplex), 1);
    chk("up_hold_18", int'(mac_tx_hold), 0);
    go(10);
    chk("up_no_sc",  sc_count,   s0);
    chk("up_speed",  int'(speed), 2);

    // Change to 100M with MAC idle
    rxd = 4'b1011;
    go(18);
    chk("m100_speed_a", int'(speed),   2);
    chk("m100_link_a",  int'(link_up), 1);
    go(1);
    chk("m100_wait_hold", int'(mac_tx_hold), 1);
    chk("m100_wait_spd",  int'(speed),       2);
    go(1);
    chk("m100_speed", int'(speed),        1);
    chk("m100_sc",    int'(speed_change), 1);
    chk("m100_phy",   int'(phy_if_rst),   1);
    go(63);
    chk("m100_phy_63",  int'(phy_if_rst),  1);
    chk("m100_hold_63", int'(mac_tx_hold), 1);
    go(1);
    chk("m100_phy_64",  int'(phy_if_rst),  0);
    chk("m100_hold_64", int'(mac_tx_hold), 0);
    chk("m100_sc_once", sc_count, s0 + 1);

    // Back to 1G while MAC is busy for 200 cycles
    busy = 1'b1;
    rxd  = 4'b1101;
    go(200);
    chk("busy_speed", int'(speed),       1);
    chk("busy_hold",  int'(mac_tx_hold), 1);
    chk("busy_phy",   int'(phy_if_rst),  0);
    busy = 1'b0;
    go(1);
    chk("busy_sw_speed", int'(speed),        2);
    chk("busy_sw_sc",    int'(speed_change), 1);
    go(64);
    chk("busy_phy_done",  int'(phy_if_rst),  0);
    chk("busy_hold_done", int'(mac_tx_hold), 0);
    chk("busy_sc_count",  sc_count, s0 + 2);

    // Toggling status with dv/er bursts never settles
    for (int k = 0; k < 4; k++) begin
      rxd = 4'b1011;
      go(8);
      dv  = 1'b1;
      rxd = 4'b1010;
      go(3);
      dv  = 1'b0;
      rxd = 4'b1101;
      go(8);
      er  = 1'b1;
      rxd = 4'b0101;
      go(3);
      er  = 1'b0;
    end
    rxd = 4'b1101;
    go(4);
    chk("tog_speed", int'(speed),   2);
    chk("tog_link",  int'(link_up), 1);
    chk("tog_sc",    sc_count, s0 + 2);

    // dv bursts pause the count rather than restarting it
    rxd = 4'b1011;
    go(10);
    dv  = 1'b1;
    rxd = 4'b1101;
    go(5);
    dv  = 1'b0;
    rxd = 4'b1011;
    go(6);
    go(3);
    chk("pause_speed_a", int'(speed), 2);
    go(1);
    chk("pause_speed", int'(speed),        1);
    chk("pause_sc",    int'(speed_change), 1);
    go(64);
    chk("pause_phy", int'(phy_if_rst), 0);

    // Reserved speed code
    rxd = 4'b1111;
    go(25);
    chk("rsv_link",  int'(link_up),     1);
    chk("rsv_speed", int'(speed),       1);
    chk("rsv_hold",  int'(mac_tx_hold), 0);
    rxd = 4'b0111;
    go(25);
    chk("rsv_fd",    int'(full_duplex), 0);
    chk("rsv_speed2", int'(speed),      1);
    chk("rsv_sc",    sc_count, s0 + 3);

    // Link drop while waiting for the MAC
    busy = 1'b1;
    rxd  = 4'b1101;
    go(25);
    chk("drop_wait_hold", int'(mac_tx_hold), 1);
    chk("drop_wait_spd",  int'(speed),       1);
    rxd = 4'b1100;
    go(20);
    chk("drop_link", int'(link_up),     0);
    chk("drop_hold", int'(mac_tx_hold), 1);
    busy = 1'b0;
    go(5);
    chk("drop_speed", int'(speed),      1);
    chk("drop_phy",   int'(phy_if_rst), 0);
    chk("drop_sc",    sc_count, s0 + 3);

    // Get to 100M HOLD, then reset mid-HOLD
    rxd = 4'b1101;
    go(90);
    chk("pre_rst_speed", int'(speed),      2);
    chk("pre_rst_phy",   int'(phy_if_rst), 0);
    rxd = 4'b1011;
    go(30);
    chk("mid_hold_speed", int'(speed),      1);
    chk("mid_hold_phy",   int'(phy_if_rst), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_speed", int'(speed),        2);
    chk("arst_link",  int'(link_up),      0);
    chk("arst_fd",    int'(full_duplex),  0);
    chk("arst_hold",  int'(mac_tx_hold),  1);
    chk("arst_phy",   int'(phy_if_rst),   1);
    chk("arst_sc",    int'(speed_change), 0);
    go(2);
    rxd = 4'b0000;
    rst = 1'b0;
    go(63);
    chk("rerun_phy_63", int'(phy_if_rst), 1);
    go(1);
    chk("rerun_phy_64", int'(phy_if_rst), 0);
    chk("rerun_speed",  int'(speed),      2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
